// File: rtl/mips_cpu_muldiv_sequencer.sv
// HI/LO multiply/divide sequencer: radix-2 shift-add multiply, restoring divide, MTHI/MTLO.
// Optional MULDIV_FAST_MUL_EN: single-cycle MULT/MULTU through a combinational product.
module mips_cpu_muldiv_sequencer #(
    parameter int unsigned                DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0]      DIV0_LO    = 32'hFFFFFFFF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_enable,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] rs,
    input  logic [DATA_WIDTH-1:0] rt,
    input  logic                  mthi,
    input  logic                  mtlo,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);
    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned CW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [W-1:0]    mcand_q, mcand_d;   // multiplicand or divisor magnitude
    logic [W-1:0]    shreg_q, shreg_d;   // multiplier (shifts right) or dividend->quotient
    logic [2*W-1:0]  acc_q, acc_d;       // product accumulator; upper half is the remainder
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            neg_res_q, neg_res_d;
    logic            neg_rem_q, neg_rem_d;
    logic            div0_q, div0_d;
    logic [W-1:0]    hi_q, hi_d, lo_q, lo_d;
    logic            done_q, done_d;

    logic            is_signed;
    logic [W-1:0]    rs_mag, rt_mag;
    logic [W:0]      rem_sh, mul_sum;
    logic [W+1:0]    trial;
    logic [W-1:0]    quo, rem;
    logic [2*W-1:0]  prod;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        mcand_d   = mcand_q;
        shreg_d   = shreg_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        is_signed = ~op[0];
        rs_mag    = (is_signed && rs[W-1]) ? -rs : rs;
        rt_mag    = (is_signed && rt[W-1]) ? -rt : rt;
        rem_sh    = {acc_q[2*W-1:W], shreg_q[W-1]};
        trial     = {1'b0, rem_sh} - {2'b00, mcand_q};
        mul_sum   = {1'b0, acc_q[2*W-1:W]} + (shreg_q[0] ? {1'b0, mcand_q} : '0);
        quo       = shreg_q;
        rem       = acc_q[2*W-1:W];
        prod      = neg_res_q ? -acc_q : acc_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    op_d      = op;
                    neg_res_d = is_signed & (rs[W-1] ^ rt[W-1]);
                    neg_rem_d = is_signed & rs[W-1];
                    div0_d    = (rt == '0);
                    acc_d     = '0;
                    cnt_d     = '0;
                    state_d   = StRun;
                    if (op[1]) begin
                        mcand_d = rt_mag;
                        shreg_d = rs_mag;
                    end else begin
                        mcand_d = rs_mag;
                        shreg_d = rt_mag;
`ifdef MULDIV_FAST_MUL_EN
                        acc_d   = (2*W)'(rs_mag) * (2*W)'(rt_mag);
                        state_d = StFix;
`endif
                    end
                end else begin
                    // start wins; MTHI/MTLO only land when no op is launched
                    if (mthi) hi_d = wdata;
                    if (mtlo) lo_d = wdata;
                end
            end
            StRun: begin
                if (op_q[1]) begin
                    if (!trial[W+1]) begin
                        acc_d[2*W-1:W] = trial[W-1:0];
                        shreg_d        = {shreg_q[W-2:0], 1'b1};
                    end else begin
                        acc_d[2*W-1:W] = rem_sh[W-1:0];
                        shreg_d        = {shreg_q[W-2:0], 1'b0};
                    end
                end else begin
                    acc_d   = {mul_sum, acc_q[W-1:1]};
                    shreg_d = shreg_q >> 1;
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(W - 1)) state_d = StFix;
            end
            StFix: begin
                if (op_q[1]) begin
                    // with a zero divisor the remainder path reassembles the dividend
                    lo_d = div0_q ? DIV0_LO : (neg_res_q ? -quo : quo);
                    hi_d = neg_rem_q ? -rem : rem;
                end else begin
                    {hi_d, lo_d} = prod;
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            op_q      <= '0;
            mcand_q   <= '0;
            shreg_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else if (clk_enable) begin
            state_q   <= state_d;
            op_q      <= op_d;
            mcand_q   <= mcand_d;
            shreg_q   <= shreg_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mips_cpu_muldiv_sequencer.sv
// Directed bench for mips_cpu_muldiv_sequencer; honours MULDIV_FAST_MUL_EN for multiply latency.
module tb_mips_cpu_muldiv_sequencer;
    logic        clk = 1'b0;
    logic        reset, clk_enable, start, mthi, mtlo;
    logic [1:0]  op;
    logic [31:0] rs, rt, wdata;
    logic        busy, done;
    logic [31:0] hi, lo;
    int          tests_run    = 0;
    int          tests_failed = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MulLat = 1;
`else
    localparam int MulLat = 33;
`endif
    localparam int DivLat = 33;

    always #5 clk = ~clk;

    mips_cpu_muldiv_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .start      (start),
        .op         (op),
        .rs         (rs),
        .rt         (rt),
        .mthi       (mthi),
        .mtlo       (mtlo),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Launch at E0, then count edges until done; optional interfering start/mtlo and stall.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int glitch_at, input int stall_at,
                          input int stall_len, input int exp_lat,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic [31:0] hi0, lo0;
        int          n;
        hi0   = hi;
        lo0   = lo;
        op    = o;
        rs    = a;
        rt    = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        check_eq({tag, "_busy"}, 32'(busy), 32'd1);
        n = 0;
        while (n < 200) begin
            if (n + 1 == glitch_at) begin
                start = 1'b1;
                op    = 2'b01;
                rs    = 32'h55;
                rt    = 32'h3;
                mtlo  = 1'b1;
                wdata = 32'h0BAD;
            end
            clk_enable = !((n + 1 >= stall_at) && (n + 1 < stall_at + stall_len));
            @(posedge clk); #1;
            n++;
            start      = 1'b0;
            mtlo       = 1'b0;
            clk_enable = 1'b1;
            if (n == 4) begin
                check_eq({tag, "_hi_hold"}, hi, hi0);
                check_eq({tag, "_lo_hold"}, lo, lo0);
            end
            if (done) break;
        end
        check_eq({tag, "_lat"}, 32'(n), 32'(exp_lat));
        check_eq({tag, "_hi"}, hi, exp_hi);
        check_eq({tag, "_lo"}, lo, exp_lo);
        check_eq({tag, "_idle"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        check_eq({tag, "_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        clk_enable = 1'b1;
        start      = 1'b0;
        mthi       = 1'b0;
        mtlo       = 1'b0;
        op         = 2'b00;
        rs         = '0;
        rt         = '0;
        wdata      = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_hi", hi, 32'd0);
        check_eq("rst_lo", lo, 32'd0);
        reset = 1'b0;

        run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, MulLat,
               32'hFFFFFFFE, 32'h00000001);
        run_op("mult_neg", 2'b00, 32'hFFFFFFF9, 32'd3, 0, 0, 0, MulLat,
               32'hFFFFFFFF, 32'hFFFFFFEB);
        run_op("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2, 0, 0, 0, DivLat,
               32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu_zero", 2'b11, 32'd100, 32'd0, 0, 0, 0, DivLat,
               32'd100, 32'hFFFFFFFF);
        run_op("div_zero_neg", 2'b10, 32'hFFFFFFF9, 32'd0, 0, 0, 0, DivLat,
               32'hFFFFFFF9, 32'hFFFFFFFF);
        run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0, DivLat,
               32'd0, 32'h80000000);
        run_op("divu_ignore", 2'b11, 32'd7, 32'd2, 5, 0, 0, DivLat, 32'd1, 32'd3);
        run_op("divu_stall", 2'b11, 32'd1000, 32'd7, 0, 10, 5, DivLat + 5, 32'd6, 32'd142);

        // mthi alongside start is dropped
        mthi  = 1'b1;
        wdata = 32'hDEAD;
        run_op("start_prio", 2'b01, 32'd2, 32'd3, 0, 0, 0, MulLat, 32'd0, 32'd6);

        // reset sampled at E10 of a MULTU aborts it
        op    = 2'b01;
        rs    = 32'hFFFFFFFF;
        rt    = 32'd2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_hi", hi, 32'd0);
        check_eq("abort_lo", lo, 32'd0);
        for (int i = 0; i < 3; i++) begin
            check_eq("abort_done", 32'(done), 32'd0);
            @(posedge clk); #1;
        end

        mthi  = 1'b1;
        wdata = 32'h1234;
        @(posedge clk); #1;
        mthi = 1'b0;
        check_eq("mthi_hi", hi, 32'h1234);
        check_eq("mthi_lo", lo, 32'd0);

        mthi  = 1'b1;
        mtlo  = 1'b1;
        wdata = 32'hABCD;
        @(posedge clk); #1;
        mthi = 1'b0;
        mtlo = 1'b0;
        check_eq("mtboth_hi", hi, 32'hABCD);
        check_eq("mtboth_lo", lo, 32'hABCD);
        check_eq("mtboth_done", 32'(done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
